// File: rtl/uart_pkg.sv
// Shared UART constants and byte type, common to the receiver, RX FIFO and TX path.
package uart_pkg;

    localparam int unsigned UART_BYTE_W           = 8;
    localparam int unsigned RXFIFO_DEPTH_LOG2_DEF = 4;
    localparam int unsigned ERR_CNT_W_DEF         = 8;

    typedef logic [UART_BYTE_W-1:0] uartByte_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on rdData
// without a read strobe. Pointers carry one extra bit to tell full from empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    output logic [WIDTH-1:0]      rdData,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rdFire;
    logic             wrFire;

    // A write into a full FIFO is only legal when a read frees a slot this cycle.
    assign rdFire = rdEn & ~empty;
    assign wrFire = wrEn & (~full | rdFire);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrFire) wrPtr <= wrPtr + PTR_W'(1);
            if (rdFire) rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wrFire) mem[wrPtr[DEPTH_LOG2-1:0]] <= wrData;
    end

    assign count  = wrPtr - rdPtr;
    assign full   = (count == PTR_W'(DEPTH));
    assign empty  = (count == '0);
    assign rdData = mem[rdPtr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detects completed frames, queues
// good bytes in a FWFT FIFO, drops and counts error frames, flags overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RXFIFO_DEPTH_LOG2_DEF,
    parameter int unsigned ERR_WIDTH  = ERR_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_BYTE_W-1:0] rxByte,
    output logic [UART_BYTE_W-1:0] rdData,
    output logic                   rdValid,
    input  logic                   rdReady,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_WIDTH-1:0]   errCount,
    input  logic                   clrStatus
);

    logic      donePrev;
    logic      errPrev;
    logic      doneEvt;
    logic      errEvt;
    logic      goodEvt;
    logic      rdFire;
    logic      ovfEvt;
    logic      wrEn;
    logic      empty;
    uartByte_t fifoData;

    assign doneEvt = rxDone & ~donePrev;
    assign errEvt  = rxErr & ~errPrev;
    assign goodEvt = doneEvt & ~rxErr;
    assign rdFire  = rdValid & rdReady;

    // A good byte is lost only when full and no read frees a slot this cycle.
    assign ovfEvt  = goodEvt & full & ~rdFire;
    assign wrEn    = goodEvt & ~ovfEvt & ~reset;
    assign rdValid = ~empty;
    assign rdData  = fifoData;

    sync_fifo_fwft #(
        .WIDTH      (UART_BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) fifo (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (wrEn),
        .wrData (rxByte),
        .rdEn   (rdReady),
        .rdData (fifoData),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Edge-detect history resets high so a level already asserted at release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            donePrev <= 1'b1;
            errPrev  <= 1'b1;
        end else begin
            donePrev <= rxDone;
            errPrev  <= rxErr;
        end
    end

    // Status: a coincident set/increment takes priority over clrStatus.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            errCount <= '0;
        end else begin
            if (ovfEvt) begin
                overflow <= 1'b1;
            end else if (clrStatus) begin
                overflow <= 1'b0;
            end

            if (errEvt) begin
                if (clrStatus) begin
                    errCount <= ERR_WIDTH'(1);
                end else if (!(&errCount)) begin
                    errCount <= errCount + ERR_WIDTH'(1);
                end
            end else if (clrStatus) begin
                errCount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: a per-cycle vector table plus
// hand-written sequences for ordering/wrap, overflow, clear priority and reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxByte;
    logic       rdReady;
    logic       clrStatus;

    logic [7:0] rdData;
    logic       rdValid;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] errCount;

    logic [7:0] rdData2;
    logic       rdValid2;
    logic [4:0] count2;
    logic       full2;
    logic       overflow2;
    logic [1:0] errCount2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady), .count(count),
        .full(full), .overflow(overflow), .errCount(errCount), .clrStatus(clrStatus)
    );

    uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .rdData(rdData2), .rdValid(rdValid2), .rdReady(rdReady), .count(count2),
        .full(full2), .overflow(overflow2), .errCount(errCount2), .clrStatus(clrStatus)
    );

    typedef struct {
        logic       done;
        logic       err;
        logic [7:0] b;
        logic       rdy;
        logic       clr;
        logic       eValid;
        logic [7:0] eData;
        logic       eDataChk;
        logic [4:0] eCount;
        logic       eFull;
        logic       eOvf;
        logic [7:0] eErr;
        logic [1:0] eErr2;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] b);
        rxDone = 1'b1;
        rxByte = b;
        step();
        rxDone = 1'b0;
        step();
    endtask

    task automatic readExp(input string name, input logic [7:0] e);
        chk({name, " valid"}, 32'(rdValid), 32'd1);
        chk({name, " data"}, 32'(rdData), 32'(e));
        rdReady = 1'b1;
        step();
        rdReady = 1'b0;
    endtask

    initial begin
        // done err byte rdy clr | valid data dchk count full ovf err err2
        vecs[0]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 8'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 8'd0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 8'd0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 8'd0, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd1, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd1, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd2, 2'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd2, 2'd2};
        vecs[9]  = '{1'b1, 1'b1, 8'h79, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd3, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd3, 2'd3};
        vecs[11] = '{1'b1, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd4, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd4, 2'd3};
        vecs[13] = '{1'b1, 1'b1, 8'h7B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd5, 2'd3};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 2'd0};

        reset = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        rdReady = 1'b0; clrStatus = 1'b0;
        step();
        step();
        chk("reset count", 32'(count), 32'd0);
        chk("reset valid", 32'(rdValid), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset ovf", 32'(overflow), 32'd0);
        chk("reset err", 32'(errCount), 32'd0);
        reset = 1'b0;
        step();

        // Single byte, error frames, saturation, clear
        for (int i = 0; i < NVEC; i++) begin
            rxDone = vecs[i].done; rxErr = vecs[i].err; rxByte = vecs[i].b;
            rdReady = vecs[i].rdy; clrStatus = vecs[i].clr;
            step();
            chk($sformatf("vec%0d valid", i), 32'(rdValid), 32'(vecs[i].eValid));
            if (vecs[i].eDataChk)
                chk($sformatf("vec%0d data", i), 32'(rdData), 32'(vecs[i].eData));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].eCount));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].eFull));
            chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].eOvf));
            chk($sformatf("vec%0d err", i), 32'(errCount), 32'(vecs[i].eErr));
            chk($sformatf("vec%0d err2", i), 32'(errCount2), 32'(vecs[i].eErr2));
        end
        rxDone = 1'b0; rxErr = 1'b0; rdReady = 1'b0; clrStatus = 1'b0;
        step();

        // Ordering and pointer wrap
        for (int i = 0; i < 16; i++) writeByte(8'(i));
        chk("wrap full", 32'(full), 32'd1);
        chk("wrap count16", 32'(count), 32'd16);
        for (int i = 0; i < 8; i++) readExp("wrap first8", 8'(i));
        chk("wrap count8", 32'(count), 32'd8);
        for (int i = 16; i < 24; i++) writeByte(8'(i));
        for (int i = 8; i < 24; i++) readExp("wrap drain", 8'(i));
        chk("wrap empty", 32'(rdValid), 32'd0);
        chk("wrap count0", 32'(count), 32'd0);
        chk("wrap ovf", 32'(overflow), 32'd0);

        // Overflow, clear priority, write+read while full
        for (int i = 0; i < 16; i++) writeByte(8'h20 + 8'(i));
        writeByte(8'hAA);
        chk("ovf flag", 32'(overflow), 32'd1);
        chk("ovf count", 32'(count), 32'd16);
        chk("ovf head", 32'(rdData), 32'h20);
        clrStatus = 1'b1;
        step();
        clrStatus = 1'b0;
        chk("clr ovf", 32'(overflow), 32'd0);
        chk("clr err", 32'(errCount), 32'd0);
        rxDone = 1'b1; rxByte = 8'hCC; clrStatus = 1'b1;
        step();
        rxDone = 1'b0; clrStatus = 1'b0;
        chk("clr vs set ovf", 32'(overflow), 32'd1);
        chk("clr vs set count", 32'(count), 32'd16);
        step();
        rxDone = 1'b1; rxByte = 8'hBB; rdReady = 1'b1;
        step();
        rxDone = 1'b0; rdReady = 1'b0;
        chk("full rw count", 32'(count), 32'd16);
        chk("full rw head", 32'(rdData), 32'h21);
        step();
        for (int i = 1; i < 16; i++) readExp("ovf drain", 8'h20 + 8'(i));
        readExp("ovf tail", 8'hBB);
        chk("ovf drained", 32'(rdValid), 32'd0);

        // Reset with bytes stored; status cleared too
        for (int i = 0; i < 5; i++) writeByte(8'h40 + 8'(i));
        chk("pre reset count", 32'(count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid reset count", 32'(count), 32'd0);
        chk("mid reset valid", 32'(rdValid), 32'd0);
        chk("mid reset ovf", 32'(overflow), 32'd0);
        step();

        // Release reset with rxDone already high
        reset = 1'b1; rxDone = 1'b1; rxByte = 8'h99;
        step();
        reset = 1'b0;
        step();
        step();
        chk("release high count", 32'(count), 32'd0);
        chk("release high valid", 32'(rdValid), 32'd0);
        rxDone = 1'b0;
        step();

        // Reset between two frames
        writeByte(8'h61);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        writeByte(8'h62);
        chk("interleave count", 32'(count), 32'd1);
        readExp("interleave data", 8'h62);
        chk("interleave empty", 32'(rdValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
